// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared digit width, default wrap value and load clamp helper
package bcd_pkg;

  localparam int DIGIT_W           = 4;
  localparam int MAX_DIGIT_DEFAULT = 9;

  // Out-of-range load nibbles saturate to the wrap value rather than
  // leaving the digit in a state the count logic never produces.
  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d,
    input logic [DIGIT_W-1:0] max_d
  );
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one registered decimal digit with clear, clamped load and up/down step
module bcd_digit
  import bcd_pkg::*;
#(
  parameter int MAX_DIGIT = MAX_DIGIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic               load,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q,
  output logic               carry,
  output logic               borrow
);

  localparam logic [DIGIT_W-1:0] MAX_Q = DIGIT_W'(MAX_DIGIT);

  logic [DIGIT_W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= clamp_digit(d, MAX_Q);
    end else if (inc) begin
      r_q <= (r_q == MAX_Q) ? '0 : r_q + 1'b1;
    end else if (dec) begin
      r_q <= (r_q == '0) ? MAX_Q : r_q - 1'b1;
    end
  end

  // Status flags, not gated by inc/dec: the parent builds both the
  // ripple chain and the terminal-count term from them.
  assign q      = r_q;
  assign carry  = (r_q == MAX_Q);
  assign borrow = (r_q == '0);

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - cascaded up/down decimal counter with wrap or saturate and overflow pulse
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int MAX_DIGIT = MAX_DIGIT_DEFAULT,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] out,
  output logic                      tc,
  output logic                      ovf
);

  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_zero;
  logic [DIGITS-1:0] w_inc;
  logic [DIGITS-1:0] w_dec;
  logic [DIGITS:0]   w_max_below;
  logic [DIGITS:0]   w_zero_below;
  logic              w_step;
  logic              r_ovf;

  assign w_max_below[0]  = 1'b1;
  assign w_zero_below[0] = 1'b1;

  assign tc     = en & (up ? w_max_below[DIGITS] : w_zero_below[DIGITS]);
  // In saturate mode the terminal step is swallowed so every digit holds.
  assign w_step = en & ~(SATURATE & tc);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign w_max_below[i+1]  = w_max_below[i] & w_at_max[i];
    assign w_zero_below[i+1] = w_zero_below[i] & w_at_zero[i];
    assign w_inc[i]          = w_step & up & w_max_below[i];
    assign w_dec[i]          = w_step & ~up & w_zero_below[i];

    bcd_digit #(
      .MAX_DIGIT(MAX_DIGIT)
    ) u_digit (
      .clk    (clk),
      .rst    (rst),
      .inc    (w_inc[i]),
      .dec    (w_dec[i]),
      .load   (load),
      .clr    (clr),
      .d      (load_val[DIGIT_W*i +: DIGIT_W]),
      .q      (out[DIGIT_W*i +: DIGIT_W]),
      .carry  (w_at_max[i]),
      .borrow (w_at_zero[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= tc & ~clr & ~load;
    end
  end

  assign ovf = r_ovf;

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - wrap and saturate instances checked against an integer reference model
module tb_bcd_counter;

  localparam int ND   = 4;
  localparam int MAXD = 9;
  localparam int BASE = MAXD + 1;
  localparam int MODV = BASE ** ND;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] out_w;
  logic [15:0] out_s;
  logic        tc_w;
  logic        tc_s;
  logic        ovf_w;
  logic        ovf_s;

  int n_tests;
  int n_fail;
  int m_val[2];
  int m_ovf[2];

  bcd_counter #(.DIGITS(ND), .MAX_DIGIT(MAXD), .SATURATE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out_w), .tc(tc_w), .ovf(ovf_w)
  );

  bcd_counter #(.DIGITS(ND), .MAX_DIGIT(MAXD), .SATURATE(1'b1)) u_dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .out(out_s), .tc(tc_s), .ovf(ovf_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_val(input logic [15:0] lv);
    int v = 0;
    int w = 1;
    for (int i = 0; i < ND; i++) begin
      int d = int'(lv[4*i +: 4]);
      if (d > MAXD) d = MAXD;
      v += d * w;
      w *= BASE;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int rem = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(rem % BASE);
      rem = rem / BASE;
    end
    return r;
  endfunction

  task automatic check_outputs();
    check("out_wrap", out_w, to_bcd(m_val[0]));
    check("out_sat", out_s, to_bcd(m_val[1]));
    check("ovf_wrap", ovf_w, m_ovf[0]);
    check("ovf_sat", ovf_s, m_ovf[1]);
  endtask

  task automatic cycle(input logic i_en, input logic i_up, input logic i_clr,
                       input logic i_load, input logic [15:0] i_lv);
    int exp_tc[2];
    en = i_en; up = i_up; clr = i_clr; load = i_load; load_val = i_lv;
    #1;
    for (int s = 0; s < 2; s++)
      exp_tc[s] = (i_en && (i_up ? (m_val[s] == MODV - 1) : (m_val[s] == 0))) ? 1 : 0;
    check("tc_wrap", tc_w, exp_tc[0]);
    check("tc_sat", tc_s, exp_tc[1]);
    @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      m_ovf[s] = (exp_tc[s] != 0 && !i_clr && !i_load) ? 1 : 0;
      if (i_clr) m_val[s] = 0;
      else if (i_load) m_val[s] = clamp_val(i_lv);
      else if (i_en) begin
        if (exp_tc[s] != 0) begin
          if (s == 0) m_val[s] = i_up ? 0 : MODV - 1;
        end else begin
          m_val[s] = i_up ? m_val[s] + 1 : m_val[s] - 1;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  // Raise rst between edges, with a load pending, and hold it across one edge.
  task automatic reset_pulse();
    load = 1'b1; load_val = 16'h5555; en = 1'b1; up = 1'b1;
    rst = 1'b1;
    #1;
    m_val[0] = 0; m_val[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    check("rst_out_now", out_w, 16'h0000);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    m_val[0] = 0; m_val[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    cycle(1, 1, 0, 1, 16'h0123);
    cycle(1, 1, 1, 1, 16'h0456);
    check("prio_clr", out_w, 16'h0000);
    cycle(0, 1, 0, 1, 16'h0C3F);
    check("clamp_load", out_w, 16'h0939);

    cycle(0, 1, 0, 1, 16'h9998);
    cycle(1, 1, 0, 0, 16'h0000);
    check("up_to_9999", out_w, 16'h9999);
    cycle(1, 1, 0, 0, 16'h0000);
    check("wrap_zero", out_w, 16'h0000);
    check("wrap_ovf", ovf_w, 1);
    cycle(0, 1, 0, 0, 16'h0000);
    check("ovf_one_cycle", ovf_w, 0);

    cycle(0, 0, 0, 1, 16'h1000);
    cycle(1, 0, 0, 0, 16'h0000);
    check("borrow", out_w, 16'h0999);
    cycle(0, 0, 1, 0, 16'h0000);
    cycle(1, 0, 0, 0, 16'h0000);
    check("down_wrap", out_w, 16'h9999);
    check("down_ovf", ovf_w, 1);

    cycle(0, 1, 0, 1, 16'h9999);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 1, 0, 0, 16'h0000);
      check("sat_hold", out_s, 16'h9999);
      check("sat_ovf", ovf_s, 1);
    end

    cycle(0, 1, 0, 1, 16'h0010);
    cycle(1, 1, 0, 0, 16'h0000);
    check("dir_up", out_w, 16'h0011);
    cycle(1, 0, 0, 0, 16'h0000);
    check("dir_down", out_w, 16'h0010);

    cycle(0, 1, 0, 1, 16'h0450);
    for (int k = 0; k < 7; k++) cycle(1, 1, 0, 0, 16'h0000);
    check("mid_count", out_w, 16'h0457);
    reset_pulse();
    cycle(1, 1, 0, 0, 16'h0000);
    check("resume", out_w, 16'h0001);

    for (int k = 0; k < 600; k++) begin
      int r;
      logic [15:0] lv;
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 5))
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        2: lv = 16'h9998;
        3: lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
      if (r < 2) reset_pulse();
      else cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 r < 5, (r >= 5) && (r < 12), lv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 SHALL provide parameter DIGITS, default 4, meaning the number of cascaded decimal digits (1..8).
REQ-002 SHALL provide parameter MAX_DIGIT, default 9, meaning the per-digit wrap value (1..15).
REQ-003 SHALL provide parameter SATURATE, default 0, meaning the mode: 0 wraps at terminal count, 1 holds at terminal count.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction: 1 counts up, 0 counts down.
REQ-008 SHALL have port clr  input  1  synchronous clear to all zeros.
REQ-009 SHALL have port load  input  1  synchronous parallel load.
REQ-010 SHALL have port load_val  input  4*DIGITS  load value, digit i at bits [4i+3:4i].
REQ-011 SHALL have port out  output  4*DIGITS  current count, digit 0 least significant.
REQ-012 SHALL have port tc  output  1  combinational terminal count.
REQ-013 SHALL have port ovf  output  1  registered one-cycle wrap/saturate event pulse.

Function
REQ-014 SHALL apply priority per edge: clr > load > en; idle holds.
REQ-015 SHALL, on clr, set every digit to 0 and ovf to 0.
REQ-016 SHALL, on load, write each digit from load_val, replacing any digit above MAX_DIGIT with MAX_DIGIT.
REQ-017 SHALL, counting up, increment digit 0; a digit at MAX_DIGIT goes to 0 and carries into the next digit in the same cycle.
REQ-018 SHALL, counting down, decrement digit 0; a digit at 0 goes to MAX_DIGIT and borrows from the next digit in the same cycle.
REQ-019 SHALL drive tc = en AND (all digits = MAX_DIGIT when up=1, all digits = 0 when up=0).
REQ-020 SHALL, with SATURATE=0 and tc=1, wrap to all-0 (up) or all-MAX_DIGIT (down).
REQ-021 SHALL, with SATURATE=1 and tc=1, hold the count unchanged.
REQ-022 SHALL set ovf to 1 for exactly the cycle after an edge where tc=1 and neither clr nor load was asserted; otherwise ovf is 0.
REQ-023 SHALL have count latency of one clock: out reflects the enable on the following edge.
REQ-024 SHALL allow a change of up between consecutive cycles without glitching or skipping a value.
REQ-025 SHALL, with DIGITS=1, MAX_DIGIT=9, SATURATE=0, en=1, up=1, count 0..9,0,...

Reset
REQ-026 SHALL, while rst=1, force out to all zeros and ovf to 0 immediately, independent of clk.
REQ-027 SHALL resume counting on the first rising edge after rst deasserts.
REQ-028 SHALL abandon any load or clr presented in the same cycle as rst.

Structure
REQ-029 SHALL place the digit width constant (4) and the default MAX_DIGIT in the shared package bcd_pkg.
REQ-030 SHALL implement each digit as sub-module bcd_digit (inputs: inc, dec, load, clr, d; outputs: q, carry, borrow), instantiated DIGITS times via a generate loop.
REQ-031 SHALL keep tc and carry chains combinational and every output except tc registered.

Verification
REQ-032 SHALL test reset mid-count: count to 0x0457, assert rst between edges -> out=0x0000 immediately, ovf=0.
REQ-033 SHALL test up wrap (SATURATE=0): load 0x9998, en=1, up=1 -> 0x9999 (tc=1), then 0x0000 with ovf=1 for one cycle.
REQ-034 SHALL test down borrow: load 0x1000, up=0, one enable -> 0x0999; from 0x0000 -> tc=1, then 0x9999 with ovf=1.
REQ-035 SHALL test saturate (SATURATE=1): from 0x9999, up=1, 5 enables -> out stays 0x9999, ovf pulses on each of the 5.
REQ-036 SHALL test priority and clamping: clr=1, load=1, en=1 at 0x0123 -> 0x0000; load 0x0C3F alone -> 0x0939.
REQ-037 SHALL test a direction change at 0x0010: up then down on consecutive edges -> 0x0011, then 0x0010.
